// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode-class helpers for the execute-stage ALU.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_EQ     = 5'd10;
  localparam logic [4:0] OP_LTU    = 5'd11;
  localparam logic [4:0] OP_LT     = 5'd12;
  localparam logic [4:0] OP_PASSB  = 5'd13;
  localparam logic [4:0] OP_MUL    = 5'd14;
  localparam logic [4:0] OP_MULH   = 5'd15;
  localparam logic [4:0] OP_MULHSU = 5'd16;
  localparam logic [4:0] OP_MULHU  = 5'd17;
  localparam logic [4:0] OP_DIV    = 5'd18;
  localparam logic [4:0] OP_DIVU   = 5'd19;
  localparam logic [4:0] OP_REM    = 5'd20;
  localparam logic [4:0] OP_REMU   = 5'd21;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } alu_state_e;

  function automatic logic is_mul(logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div(logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Purely combinational single-cycle ALU ops; M-extension and undefined codes yield 0.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [4:0]            op_i,
  input  logic                  funct3b0_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int unsigned ShW = $clog2(DATA_WIDTH);

  logic [ShW-1:0] shamt;
  logic           lt_s;
  logic           lt_u;
  logic           eq;

  assign shamt = b_i[ShW-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:   res_o = a_i + b_i;
      OP_SUB:   res_o = a_i - b_i;
      OP_SLL:   res_o = a_i << shamt;
      OP_SLT:   res_o[0] = lt_s;
      OP_SLTU:  res_o[0] = lt_u;
      OP_XOR:   res_o = a_i ^ b_i;
      OP_SRL:   res_o = a_i >> shamt;
      OP_SRA:   res_o = DATA_WIDTH'($signed(a_i) >>> shamt);
      OP_OR:    res_o = a_i | b_i;
      OP_AND:   res_o = a_i & b_i;
      OP_EQ:    res_o[0] = eq ^ funct3b0_i;
      OP_LTU:   res_o[0] = lt_u ^ funct3b0_i;
      OP_LT:    res_o[0] = lt_s ^ funct3b0_i;
      OP_PASSB: res_o = b_i;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered single-cycle ops plus iterative shift-add multiply and
// restoring divide; in_ready drops while a multi-cycle op is in flight.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_UNROLL = 1,
  parameter int unsigned MULDIV_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [4:0]            alu_controls,
  input  logic                  funct3b0,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  busy
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] MulLast = CntW'(DATA_WIDTH / MUL_UNROLL - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(DATA_WIDTH - 1);
  localparam logic [W-1:0]    MinVal  = {1'b1, {(W-1){1'b0}}};

  alu_state_e     state_q, state_d;
  logic [W-1:0]   res_q, res_d;
  logic           out_valid_q, out_valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic           neg_q, neg_d;
  logic           sel_q, sel_d;  // MUL: take high half; DIV: take remainder

  logic [W-1:0]   comb_res;

  alu_comb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu_comb (
    .a_i       (a),
    .b_i       (b),
    .op_i      (alu_controls),
    .funct3b0_i(funct3b0),
    .res_o     (comb_res)
  );

  // Operand conditioning at accept
  logic         a_sgn, b_sgn, sa, sb, op_rem, div_ovf;
  logic [W-1:0] mag_a, mag_b;

  always_comb begin
    a_sgn   = (alu_controls == OP_MULH) || (alu_controls == OP_MULHSU) ||
              (alu_controls == OP_DIV)  || (alu_controls == OP_REM);
    b_sgn   = (alu_controls == OP_MULH) || (alu_controls == OP_DIV) ||
              (alu_controls == OP_REM);
    sa      = a_sgn & a[W-1];
    sb      = b_sgn & b[W-1];
    mag_a   = sa ? -a : a;
    mag_b   = sb ? -b : b;
    op_rem  = (alu_controls == OP_REM) || (alu_controls == OP_REMU);
    div_ovf = ((alu_controls == OP_DIV) || (alu_controls == OP_REM)) &&
              (a == MinVal) && (b == '1);
  end

  // One iteration of each datapath; the last iteration's result feeds res directly
  logic [2*W-1:0] acc_n, mc, prod;
  logic [W-1:0]   mp;
  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   rem_n, quo_n, q_fin, r_fin;

  always_comb begin
    acc_n = acc_q;
    mc    = mcand_q;
    mp    = mplier_q;
    for (int i = 0; i < int'(MUL_UNROLL); i++) begin
      if (mp[0]) acc_n = acc_n + mc;
      mc = mc << 1;
      mp = mp >> 1;
    end
    prod = neg_q ? -acc_n : acc_n;

    shifted = {rem_q, quo_q[W-1]};
    ge      = shifted >= {1'b0, dvsr_q};
    rem_n   = ge ? (shifted[W-1:0] - dvsr_q) : shifted[W-1:0];
    quo_n   = {quo_q[W-2:0], ge};
    q_fin   = neg_q ? -quo_n : quo_n;
    r_fin   = neg_q ? -rem_n : rem_n;
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    neg_d       = neg_q;
    sel_d       = sel_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if ((MULDIV_EN != 0) && is_mul(alu_controls)) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, mag_a};
            mplier_d = mag_b;
            cnt_d    = '0;
            neg_d    = sa ^ sb;
            sel_d    = alu_controls != OP_MUL;
            state_d  = StMul;
          end else if ((MULDIV_EN != 0) && is_div(alu_controls)) begin
            if (b == '0) begin
              res_d       = op_rem ? a : '1;
              out_valid_d = 1'b1;
            end else if (div_ovf) begin
              res_d       = op_rem ? '0 : MinVal;
              out_valid_d = 1'b1;
            end else begin
              rem_d   = '0;
              quo_d   = mag_a;
              dvsr_d  = mag_b;
              cnt_d   = '0;
              neg_d   = op_rem ? sa : (sa ^ sb);
              sel_d   = op_rem;
              state_d = StDiv;
            end
          end else begin
            res_d       = comb_res;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d    = acc_n;
        mcand_d  = mc;
        mplier_d = mp;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == MulLast) begin
          res_d       = sel_q ? prod[2*W-1:W] : prod[W-1:0];
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      StDiv: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DivLast) begin
          res_d       = sel_q ? r_fin : q_fin;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including an accept in the same cycle
    if (flush) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
      res_d       = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_q       <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      neg_q       <= neg_d;
      sel_q       <= sel_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign out_valid = out_valid_q;
  assign res       = res_q;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised execute-stage ALU with integrated iterative RV32M multiply/divide.
- Single-cycle ops return a registered result one cycle after issue.
- MUL* and DIV*/REM* run in a multi-cycle FSM; the unit deasserts in_ready so the hazard unit stalls issue.
- Sits in the execute stage; it is fed by the ID/EX register and drives the EX/MEM result mux.

Parameters:
DATA_WIDTH, 32, operand/result width; must be a power of two, 8 or greater.
MUL_UNROLL, 1, multiplier bits retired per cycle (1, 2 or 4); must divide DATA_WIDTH.
MULDIV_EN, 1, 0 removes the mul/div datapath; M opcodes then return 0 with single-cycle latency.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operation presented on a, b, alu_controls, funct3b0.
in_ready  out  1  unit can accept; equals (state==IDLE).
a  in  DATA_WIDTH  operand A (rs1).
b  in  DATA_WIDTH  operand B (rs2 or immediate).
alu_controls  in  5  opcode, see Behaviour.
funct3b0  in  1  inverts the compare result for branch opcodes.
flush  in  1  abort any in-flight operation (branch mispredict or trap).
out_valid  out  1  single-cycle pulse: res is valid this cycle.
res  out  DATA_WIDTH  registered result; holds its value until the next out_valid.
busy  out  1  multi-cycle op in flight; equals (state==MUL or state==DIV).

Behaviour:
- Opcodes, single-cycle group:
  - 00000 add; 00001 sub; 00010 sll.
  - 00011 slt; 00100 sltu; 00101 xor.
  - 00110 srl; 00111 sra; 01000 or; 01001 and.
  - 01010 eq^funct3b0; 01011 ltu^funct3b0; 01100 lt^funct3b0.
  - 01101 pass b.
  - Shift amount is b[$clog2(DATA_WIDTH)-1:0]. Compares yield 1 or 0, zero-extended.
- Opcodes, multi-cycle group:
  - 01110 MUL; 01111 MULH; 10000 MULHSU; 10001 MULHU.
  - 10010 DIV; 10011 DIVU; 10100 REM; 10101 REMU.
  - Any other code: result 0, single-cycle.
- Reset (asynchronous, any state): state=IDLE, res=0, out_valid=0, busy=0, all iteration registers=0. in_ready=1 once rst drops.
- FSM states: IDLE, MUL, DIV.
  - IDLE: on accept (in_valid and in_ready, flush=0):
    - single-cycle op: res<=op result and out_valid<=1 at the next edge; stay IDLE. Back-to-back issue every cycle is allowed.
    - mul op: latch |a| and |b| (signedness per opcode) and the result sign; go to MUL.
    - div/rem op: latch likewise; go to DIV.
  - MUL: shift-add MUL_UNROLL bits per cycle over a 2*DATA_WIDTH accumulator. After DATA_WIDTH/MUL_UNROLL cycles, negate if the sign is set, select the low half (MUL) or the high half; res updates, out_valid pulses, return to IDLE.
  - DIV: restoring radix-2, one quotient bit per cycle, DATA_WIDTH cycles. Then apply signs: quotient sign = sa^sb, remainder sign = sa. res updates, out_valid pulses, return to IDLE.
- Latency, counted from the accept edge to the out_valid cycle:
  - single-cycle ops: 1.
  - MUL*: DATA_WIDTH/MUL_UNROLL+1.
  - DIV*/REM*: DATA_WIDTH+1.
- Division special cases, resolved at accept with latency 1 and no DIV state:
  - b==0: quotient = all ones, remainder = a.
  - Signed a==MIN and b==-1: quotient = MIN, remainder = 0.
- Sign handling:
  - MULHSU treats a as signed and b as unsigned.
  - Magnitude of MIN is handled in DATA_WIDTH+1 bits or as an unsigned reinterpretation; no overflow trap.
- flush:
  - Forces state to IDLE next edge and suppresses any out_valid due that edge; res is unchanged.
  - flush with in_valid in the same cycle: nothing is accepted.
- in_valid while not ready: ignored. The issuer must hold its inputs; the unit does not capture them.
- The iteration counter is sized $clog2(DATA_WIDTH)+1 bits and does not wrap within an operation.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_REMU);
  - the state encoding (IDLE, MUL, DIV);
  - helper functions is_mul(op) and is_div(op).
- One natural sub-module: alu_comb, the purely combinational single-cycle op unit. alu_muldiv instantiates it and owns the FSM, iteration datapath and output register.

Test Plan:
- Single-cycle stream: add 5+7, sub 3-5, sra 0x80000000>>>4, issued on consecutive cycles -> res 12, 0xFFFFFFFE, 0xF8000000 on three consecutive out_valid pulses; in_ready stays 1.
- MUL 0xFFFFFFFF*0xFFFFFFFF with MULH, MULHU and MUL, one after another -> MULH 0x00000000, MULHU 0xFFFFFFFE, MUL 0x00000001. Each out_valid arrives 33 cycles after accept at MUL_UNROLL=1 (9 at MUL_UNROLL=4); in_ready=0 while busy.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each completes 33 cycles after accept.
- DIV 0x80000000/-1 -> 0x80000000; DIVU 9/0 -> 0xFFFFFFFF; REM 9/0 -> 9. All three complete with latency 1.
- Assert flush at cycle 10 of a DIV -> no out_valid pulse, in_ready=1 next cycle, res unchanged. A new add issued immediately after completes correctly.
- Assert rst mid-MUL -> out_valid, busy and res go to 0 immediately (asynchronous reset); after release in_ready=1 and a MULHU 3*5 returns 0.
